// File: rtl/addsub_accum_pkg.sv
// addsub_accum_pkg
//   Shared types and helpers for the multi-channel add/sub accumulator.
//   op_t   : 2-bit operation encoding
//              00 A+B, 01 A-B, 10 acc+A, 11 acc-A
//              bit[1] selects the accumulator as the left operand, bit[0] means subtract.
//   sat_val: signed saturation limit for an n-bit result (n <= 64).
//            sign=0 gives the positive limit 2^(n-1)-1, sign=1 gives -2^(n-1).
package addsub_accum_pkg;

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_ACC_ADD = 2'b10,
        OP_ACC_SUB = 2'b11
    } op_t;

    // Only the low n bits of the return value are meaningful; callers truncate.
    function automatic logic [63:0] sat_val(input logic sign, input int n);
        logic [63:0] lim;
        lim = 64'd1 << (n - 1);
        return sign ? lim : (lim - 64'd1);
    endfunction

endpackage

// File: rtl/addsub_accum_core.sv
// addsub_core
//   Combinational arithmetic for the second pipeline stage.
//   Ports:
//     op        in   op_t  operation (selects G/H and subtract)
//     a, b      in   N     operands from the first stage
//     acc_val   in   N     current accumulator of the target channel
//     m         out  N     raw sum G + (H ^ {N{sub}}) + sub
//     carry_out out  1     carry out of the MSB
//     ovf       out  1     signed overflow of m
//   Parameter N: operand width (two's complement).
module addsub_core
    import addsub_accum_pkg::*;
#(
    parameter int N = 16
) (
    input  op_t          op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] acc_val,
    output logic [N-1:0] m,
    output logic         carry_out,
    output logic         ovf
);

    logic [N-1:0] g;
    logic [N-1:0] h;
    logic [N-1:0] h_inv;
    logic         sub;

    always_comb begin
        g   = op[1] ? acc_val : a;
        h   = op[1] ? a : b;
        sub = op[0];
    end

    assign h_inv = h ^ {N{sub}};
    assign {carry_out, m} = {1'b0, g} + {1'b0, h_inv} + {{N{1'b0}}, sub};

    // Carry into the MSB is g^h_inv^m at bit N-1; overflow is that XOR carry out.
    assign ovf = carry_out ^ g[N-1] ^ h_inv[N-1] ^ m[N-1];

endmodule

// File: rtl/addsub_accum.sv
// addsub_accum
//   Two-stage pipelined signed add/subtract unit with CH per-channel
//   accumulators and valid/ready handshakes on both sides.
//   S1 registers the op; S2 computes the result into the output registers
//   and writes it back to acc[ch] on the same edge.
//   Optional build macro SATURATE_EN: saturate Z and acc on overflow instead
//   of wrapping. Overflow is flagged either way.
//   Ports:
//     Clock       in   1    clock, all updates on posedge
//     Reset       in   1    synchronous, active-high
//     in_valid    in   1    input op present
//     in_ready    out  1    op can be accepted this cycle
//     in_op       in   2    operation (see op_t)
//     in_ch       in   CW   target channel
//     A, B        in   N    operands (B ignored for accumulator ops)
//     out_valid   out  1    result present
//     out_ready   in   1    consumer takes result
//     out_ch      out  CW   channel of result
//     Z           out  N    result
//     Overflow    out  1    signed overflow of this result
//     ovf_sticky  out  CH   per-channel sticky overflow, cleared only by Reset
module addsub_accum
    import addsub_accum_pkg::*;
#(
    parameter int N  = 16,
    parameter int CH = 4,
    parameter int CW = $clog2(CH)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [CW-1:0] in_ch,
    input  logic [N-1:0]  A,
    input  logic [N-1:0]  B,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_ch,
    output logic [N-1:0]  Z,
    output logic          Overflow,
    output logic [CH-1:0] ovf_sticky
);

    logic          s1_valid;
    op_t           s1_op;
    logic [CW-1:0] s1_ch;
    logic [N-1:0]  s1_a;
    logic [N-1:0]  s1_b;

    logic [N-1:0]  acc [CH];

    logic          stall;
    logic          s2_load;
    logic          ch_ok;
    logic [N-1:0]  acc_rd;
    logic [N-1:0]  m_s2;
    logic          ovf_s2;
    logic [N-1:0]  z_nxt;
    logic          ovf_nxt;
`ifdef SATURATE_EN
    logic          carry_s2;
`endif

    assign stall    = out_valid & ~out_ready;
    assign s2_load  = s1_valid & ~stall;
    assign in_ready = ~s1_valid | ~stall;

    // Channel indices past CH (non power-of-two CH) are accepted but produce
    // a zero result and never touch acc or sticky state.
    assign ch_ok = ({1'b0, s1_ch} < (CW + 1)'(CH));

    // Read acc through a compare loop so an out-of-range index reads zero.
    always_comb begin
        acc_rd = '0;
        for (int i = 0; i < CH; i++) begin
            if (s1_ch == CW'(i)) acc_rd = acc[i];
        end
    end

    addsub_core #(.N(N)) u_core (
        .op        (s1_op),
        .a         (s1_a),
        .b         (s1_b),
        .acc_val   (acc_rd),
        .m         (m_s2),
`ifdef SATURATE_EN
        .carry_out (carry_s2),
`else
        .carry_out (),
`endif
        .ovf       (ovf_s2)
    );

    always_comb begin
        z_nxt   = m_s2;
        ovf_nxt = ovf_s2;
        if (!ch_ok) begin
            z_nxt   = '0;
            ovf_nxt = 1'b0;
        end
`ifdef SATURATE_EN
        // On signed overflow both effective operands share a sign, so the
        // carry out equals the sign of the true result.
        else if (ovf_s2) begin
            z_nxt = N'(sat_val(carry_s2, N));
        end
`endif
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1_valid   <= 1'b0;
            s1_op      <= OP_ADD;
            s1_ch      <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            Z          <= '0;
            Overflow   <= 1'b0;
            ovf_sticky <= '0;
            for (int i = 0; i < CH; i++) acc[i] <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_op <= op_t'(in_op);
                    s1_ch <= in_ch;
                    s1_a  <= A;
                    s1_b  <= B;
                end
            end

            if (!stall) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_ch   <= s1_ch;
                    Z        <= z_nxt;
                    Overflow <= ovf_nxt;
                end
            end

            for (int i = 0; i < CH; i++) begin
                if (s2_load && ch_ok && (s1_ch == CW'(i))) begin
                    acc[i] <= z_nxt;
                    if (ovf_nxt) ovf_sticky[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_addsub_accum.sv
// tb_addsub_accum
//   Self-checking bench for addsub_accum: directed vector table, a stall
//   sequence, a reset-in-flight sequence and randomized ops with random
//   backpressure checked against an integer-arithmetic reference model.
module tb_addsub_accum;

    localparam int N  = 16;
    localparam int CH = 4;
    localparam int CW = 2;
`ifdef SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          Clock;
    logic          Reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [CW-1:0] in_ch;
    logic [N-1:0]  A;
    logic [N-1:0]  B;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ch;
    logic [N-1:0]  Z;
    logic          Overflow;
    logic [CH-1:0] ovf_sticky;

    addsub_accum #(.N(N), .CH(CH), .CW(CW)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_ch      (in_ch),
        .A          (A),
        .B          (B),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .Z          (Z),
        .Overflow   (Overflow),
        .ovf_sticky (ovf_sticky)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  ch;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] z;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] z;
        logic        ovf;
    } exp_t;

    exp_t             q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    logic signed [15:0] m_acc [CH];
    logic [CH-1:0]    m_sticky;
    int               stall_cycles = 0;
    bit               rand_bp = 1'b0;
    bit               saw_busy = 1'b0;
    vec_t             tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural rules.
    function automatic exp_t model(input logic [1:0] op, input logic [1:0] ch,
                                   input logic [15:0] a, input logic [15:0] b);
        int   g;
        int   h;
        int   r;
        exp_t e;
        g = op[1] ? int'(m_acc[ch]) : int'($signed(a));
        h = op[1] ? int'($signed(a)) : int'($signed(b));
        r = op[0] ? (g - h) : (g + h);
        e.ch  = ch;
        e.ovf = (r > 32767) || (r < -32768);
        if (SAT && e.ovf) e.z = (r > 0) ? 16'h7FFF : 16'h8000;
        else              e.z = r[15:0];
        m_acc[ch] = e.z;
        if (e.ovf) m_sticky[ch] = 1'b1;
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < CH; i++) m_acc[i] = '0;
        m_sticky = '0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [1:0] ch,
                        input logic [15:0] a, input logic [15:0] b,
                        input bit use_exp, input exp_t texp);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        in_valid = 1'b1;
        in_op = op;
        in_ch = ch;
        A = a;
        B = b;
        for (int t = 0; t < 200 && !ok; t++) begin
            if (stall_cycles > 0) begin
                out_ready = 1'b0;
                stall_cycles--;
            end else if (rand_bp) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (in_ready) ok = 1'b1;
            else          saw_busy = 1'b1;
            @(posedge Clock);
            @(negedge Clock);
        end
        in_valid = 1'b0;
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            e = model(op, ch, a, b);
            if (use_exp) e = texp;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge Clock);
        repeat (2) @(negedge Clock);
        chk("drain_empty", q.size(), 32'd0);
    endtask

    // Output monitor: sampled mid-cycle, sees what transfers on the next edge.
    logic        hold;
    logic [1:0]  hch;
    logic [15:0] hz;
    logic        hovf;
    exp_t        ce;

    always @(negedge Clock) begin
        #2;
        if (Reset) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'({out_ch, Z, Overflow}), 32'({hch, hz, hovf}));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    ce = q.pop_front();
                    chk("result", 32'({out_ch, Z, Overflow}), 32'({ce.ch, ce.z, ce.ovf}));
                end
                hold = 1'b0;
            end else if (out_valid) begin
                hold = 1'b1;
                hch  = out_ch;
                hz   = Z;
                hovf = Overflow;
            end else begin
                hold = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        Reset = 1'b1;
        in_valid = 1'b0;
        in_op = '0;
        in_ch = '0;
        A = '0;
        B = '0;
        out_ready = 1'b1;
        model_clear();

        tbl[0]  = '{2'b00, 2'd0, 16'd5,    16'd3,    16'd8,    1'b0};
        tbl[1]  = '{2'b10, 2'd0, 16'd0,    16'd0,    16'd8,    1'b0};
        tbl[2]  = '{2'b10, 2'd1, 16'd100,  16'd0,    16'd100,  1'b0};
        tbl[3]  = '{2'b10, 2'd1, 16'd100,  16'd0,    16'd200,  1'b0};
        tbl[4]  = '{2'b10, 2'd1, 16'd100,  16'd0,    16'd300,  1'b0};
        tbl[5]  = '{2'b00, 2'd2, 16'h7FFF, 16'd1,    SAT ? 16'h7FFF : 16'h8000, 1'b1};
        tbl[6]  = '{2'b01, 2'd3, 16'h8000, 16'd1,    SAT ? 16'h8000 : 16'h7FFF, 1'b1};
        tbl[7]  = '{2'b11, 2'd1, 16'd50,   16'd0,    16'd250,  1'b0};
        tbl[8]  = '{2'b01, 2'd0, 16'd3,    16'd10,   16'hFFF9, 1'b0};
        tbl[9]  = '{2'b10, 2'd3, 16'd0,    16'd0,    SAT ? 16'h8000 : 16'h7FFF, 1'b0};
        tbl[10] = '{2'b10, 2'd2, 16'hFFFF, 16'd0,    SAT ? 16'h7FFE : 16'h7FFF, ~SAT};
        tbl[11] = '{2'b00, 2'd1, 16'h8000, 16'hFFFF, SAT ? 16'h8000 : 16'h7FFF, 1'b1};

        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        #2;
        chk("reset_in_ready",  32'(in_ready),   32'd1);
        chk("reset_out_valid", 32'(out_valid),  32'd0);
        chk("reset_Z",         32'(Z),          32'd0);
        chk("reset_Overflow",  32'(Overflow),   32'd0);
        chk("reset_sticky",    32'(ovf_sticky), 32'd0);
        @(negedge Clock);

        // Directed vectors, issued back-to-back.
        for (int i = 0; i < 12; i++) begin
            e.ch  = tbl[i].ch;
            e.z   = tbl[i].z;
            e.ovf = tbl[i].ovf;
            send(tbl[i].op, tbl[i].ch, tbl[i].a, tbl[i].b, 1'b1, e);
        end
        drain();
        chk("sticky_directed", 32'(ovf_sticky), 32'(4'b1110));

        // Stream of six ops with the consumer stalled for three cycles.
        saw_busy = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (i == 3) stall_cycles = 3;
            send(2'b10, 2'd0, 16'(i), 16'd0, 1'b0, e);
        end
        drain();
        chk("stall_in_ready_dropped", 32'(saw_busy), 32'd1);

        // Reset with two ops in flight.
        send(2'b00, 2'd0, 16'h7FFF, 16'h7FFF, 1'b0, e);
        send(2'b10, 2'd1, 16'd9, 16'd0, 1'b0, e);
        Reset = 1'b1;
        q.delete();
        @(negedge Clock);
        Reset = 1'b0;
        model_clear();
        #2;
        chk("rst_flight_out_valid", 32'(out_valid),  32'd0);
        chk("rst_flight_in_ready",  32'(in_ready),   32'd1);
        chk("rst_flight_sticky",    32'(ovf_sticky), 32'd0);
        @(negedge Clock);
        e.ch = 2'd0; e.z = 16'd7; e.ovf = 1'b0;
        send(2'b10, 2'd0, 16'd7, 16'd0, 1'b1, e);
        for (int c = 1; c < CH; c++) begin
            e.ch = 2'(c); e.z = 16'd0; e.ovf = 1'b0;
            send(2'b10, 2'(c), 16'd0, 16'd0, 1'b1, e);
        end
        drain();

        // Randomized ops with random backpressure against the model.
        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 511)) - 16'd256
                                             : 16'($urandom);
            rb = 16'($urandom);
            send(2'($urandom_range(0, 3)), 2'($urandom_range(0, CH - 1)), ra, rb, 1'b0, e);
        end
        rand_bp = 1'b0;
        drain();
        chk("sticky_random", 32'(ovf_sticky), 32'(m_sticky));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
